// File: rtl/fm_pkg.sv
// Shared FM chain definitions: CORDIC arctangent table, demodulator FSM states, phase constants.
// Latency: n/a (declarations and a constant lookup function only).
// Backpressure: n/a.
package fm_pkg;

    // Phase constants in 2^32-per-turn units; shift right to reach any narrower phase word.
    localparam logic [31:0] PHASE_HALF_PI = 32'h4000_0000;
    localparam logic [31:0] PHASE_PI      = PHASE_HALF_PI << 1;

    // atan(2^-k) in 2^16-per-turn units (45 deg == 8192); entries past k=14 round to zero.
    localparam logic [15:0] ATAN_TABLE [32] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
        16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0,
        16'd0,    16'd0,    16'd0,    16'd0,    16'd0,   16'd0,   16'd0,   16'd0,
        16'd0,    16'd0,    16'd0,    16'd0,    16'd0,   16'd0,   16'd0,   16'd0
    };

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRE    = 3'd1,
        ST_ROT    = 3'd2,
        ST_DIFF   = 3'd3,
        ST_DEEMPH = 3'd4
    } fm_state_t;

    // Table entry k rescaled to a phase word of pw bits (2^pw per turn).
    function automatic logic [31:0] atan_lut(input logic [4:0] k, input int pw);
        logic [31:0] base;
        base = {16'd0, ATAN_TABLE[k]};
        if (pw >= 16) begin
            atan_lut = base << (pw - 16);
        end else begin
            atan_lut = base >> (16 - pw);
        end
    endfunction

endpackage

// File: rtl/cordic_vectoring_iter.sv
// One CORDIC vectoring micro-rotation: drives y toward zero, accumulating the rotated angle in z.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller sequences iterations and holds the registers.
module cordic_vectoring_iter
    import fm_pkg::*;
#(
    parameter int XW = 18,
    parameter int PW = 16
) (
    input  logic [XW-1:0] x_in,
    input  logic [XW-1:0] y_in,
    input  logic [PW-1:0] z_in,
    input  logic [4:0]    k,
    output logic [XW-1:0] x_out,
    output logic [XW-1:0] y_out,
    output logic [PW-1:0] z_out
);

    logic [XW-1:0] x_sh;
    logic [XW-1:0] y_sh;
    logic [PW-1:0] atan_k;

    // Rotate clockwise when y is non-negative, counter-clockwise otherwise; z wraps modulo 2^PW.
    always_comb begin
        x_sh   = XW'($signed(x_in) >>> k);
        y_sh   = XW'($signed(y_in) >>> k);
        atan_k = PW'(atan_lut(k, PW));
        if (!y_in[XW-1]) begin
            x_out = x_in + y_sh;
            y_out = y_in - x_sh;
            z_out = z_in + atan_k;
        end else begin
            x_out = x_in - y_sh;
            y_out = y_in + x_sh;
            z_out = z_in - atan_k;
        end
    end

endmodule

// File: rtl/fm_demodulator.sv
// FM demodulator: CORDIC phase of strobed I/Q, output is the wrapped sample-to-sample phase step.
// Latency: stb_in at edge n -> stb_out in cycle n+ITER+2 (n+ITER+3 when FM_DEEMPH_EN is defined).
// Backpressure: none; stb_in while busy drops that sample and sets the sticky overrun flag.
module fm_demodulator
    import fm_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int PHASE_WIDTH = 16,
    parameter int ITER        = 14
`ifdef FM_DEEMPH_EN
    ,
    parameter int DEEMPH_SHIFT = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic [WIDTH-1:0] data_in_q,
    input  logic             stb_in,
    output logic [WIDTH-1:0] data_out,
    output logic             stb_out,
    output logic             busy,
    output logic             overrun
);

    // Two guard bits absorb the CORDIC gain (~1.647) and the exact negation of the most negative input.
    localparam int XW = WIDTH + 2;
    localparam logic [PHASE_WIDTH-1:0] Z_PI = PHASE_WIDTH'(PHASE_PI >> (32 - PHASE_WIDTH));

    fm_state_t state, state_nxt;

    logic [WIDTH-1:0]       i_cap, q_cap;
    logic [XW-1:0]          x_r, y_r;
    logic [PHASE_WIDTH-1:0] z_r;
    logic [4:0]             k_r;
    logic [PHASE_WIDTH-1:0] prev_phase;

    logic [XW-1:0]          i_ext, q_ext, x_pre, y_pre;
    logic [PHASE_WIDTH-1:0] z_pre;
    logic [XW-1:0]          x_nxt, y_nxt;
    logic [PHASE_WIDTH-1:0] z_nxt;
    logic [PHASE_WIDTH-1:0] dphi;
    logic [WIDTH-1:0]       dphi_scaled;

    cordic_vectoring_iter #(
        .XW (XW),
        .PW (PHASE_WIDTH)
    ) u_iter (
        .x_in  (x_r),
        .y_in  (y_r),
        .z_in  (z_r),
        .k     (k_r),
        .x_out (x_nxt),
        .y_out (y_nxt),
        .z_out (z_nxt)
    );

    // Fold the left half-plane onto the right by a pi rotation so the micro-steps always converge.
    always_comb begin
        i_ext = XW'($signed(i_cap));
        q_ext = XW'($signed(q_cap));
        if (i_ext[XW-1]) begin
            x_pre = -i_ext;
            y_pre = -q_ext;
            z_pre = Z_PI;
        end else begin
            x_pre = i_ext;
            y_pre = q_ext;
            z_pre = '0;
        end
    end

    // Modular subtraction read as signed gives the shortest arc between successive phases.
    assign dphi = z_r - prev_phase;

    if (WIDTH >= PHASE_WIDTH) begin : g_scale_up
        assign dphi_scaled = WIDTH'($signed(dphi)) <<< (WIDTH - PHASE_WIDTH);
    end else begin : g_scale_down
        assign dphi_scaled = WIDTH'($signed(dphi) >>> (PHASE_WIDTH - WIDTH));
    end

`ifdef FM_DEEMPH_EN
    localparam int YW = WIDTH + DEEMPH_SHIFT;
    logic [WIDTH-1:0] dphi_r;
    logic [YW-1:0]    iir_y, iir_err, iir_nxt;

    // Single-pole low-pass; extra fraction bits keep the small steps from being lost.
    assign iir_err = YW'($signed(dphi_r)) - iir_y;
    assign iir_nxt = iir_y + YW'($signed(iir_err) >>> DEEMPH_SHIFT);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state sequencing: one PRE cycle, ITER rotations, then the difference stage.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (stb_in) state_nxt = ST_PRE;
            ST_PRE:    state_nxt = ST_ROT;
            ST_ROT:    if (k_r == 5'(ITER - 1)) state_nxt = ST_DIFF;
`ifdef FM_DEEMPH_EN
            ST_DIFF:   state_nxt = ST_DEEMPH;
            ST_DEEMPH: state_nxt = ST_IDLE;
`else
            ST_DIFF:   state_nxt = ST_IDLE;
`endif
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: capture, CORDIC iterations, phase difference and output strobing.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_cap      <= '0;
            q_cap      <= '0;
            x_r        <= '0;
            y_r        <= '0;
            z_r        <= '0;
            k_r        <= '0;
            prev_phase <= '0;
            data_out   <= '0;
            stb_out    <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
`ifdef FM_DEEMPH_EN
            dphi_r     <= '0;
            iir_y      <= '0;
`endif
        end else begin
            stb_out <= 1'b0;
            if (stb_in && busy) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (stb_in) begin
                        i_cap <= data_in_i;
                        q_cap <= data_in_q;
                        busy  <= 1'b1;
                    end
                end
                ST_PRE: begin
                    x_r <= x_pre;
                    y_r <= y_pre;
                    z_r <= z_pre;
                    k_r <= '0;
                end
                ST_ROT: begin
                    x_r <= x_nxt;
                    y_r <= y_nxt;
                    z_r <= z_nxt;
                    k_r <= k_r + 5'd1;
                end
                ST_DIFF: begin
                    prev_phase <= z_r;
`ifdef FM_DEEMPH_EN
                    dphi_r     <= dphi_scaled;
`else
                    data_out   <= dphi_scaled;
                    stb_out    <= 1'b1;
                    busy       <= 1'b0;
`endif
                end
`ifdef FM_DEEMPH_EN
                ST_DEEMPH: begin
                    iir_y    <= iir_nxt;
                    data_out <= iir_nxt[WIDTH-1:0];
                    stb_out  <= 1'b1;
                    busy     <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
